mcu_spi: RTL and testbench
==========================

MCU_SPI -- requirements
Module: mcu_spi

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops per SPI input (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port spi_io_ss, input, 1 bit: MCU slave select, active low, asynchronous to clk.
REQ-005 The block SHALL have port spi_io_clk, input, 1 bit: SPI clock, mode 0 (idles low; MOSI sampled on rising edge, MISO changed on falling edge), asynchronous to clk.
REQ-006 The block SHALL have port spi_io_din, input, 1 bit: MOSI, MSB first.
REQ-007 The block SHALL have port spi_io_dout, output, 1 bit: MISO, MSB first.
REQ-008 The block SHALL have port data_in_strobe, output, 1 bit: one-clk pulse per received complete byte.
REQ-009 The block SHALL have port data_in_start, output, 1 bit: high only with the strobe of the first byte of a transaction.
REQ-010 The block SHALL have port data_in, output, 8 bits: last received byte, valid from the strobe cycle until the next strobe.
REQ-011 The block SHALL have port data_out, input, 8 bits: the byte the consumer returns to the MCU on the next byte slot.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-clk pulse when a transaction ends mid-byte.

Function
REQ-013 The block SHALL pass spi_io_ss, spi_io_clk and spi_io_din through SYNC_STAGES flops each, with reset values 1, 0 and 0 respectively.
REQ-014 The block SHALL detect SCLK rising and falling edges and SS falling and rising edges by comparing the synchronised value with a one-cycle-delayed copy.
REQ-015 The block SHALL use two states: IDLE (synchronised SS high) and ACTIVE (synchronised SS low).
REQ-016 The block SHALL move from IDLE to ACTIVE on an SS falling edge, clearing the 3-bit bit counter, setting the first-byte flag and loading the tx shift register with data_out.
REQ-017 In ACTIVE, each SCLK rising edge SHALL shift synchronised MOSI into bit 0 of the rx shift register and increment the bit counter modulo 8.
REQ-018 When the counter wraps 7->0, the block SHALL, in the next clk cycle, drive data_in = assembled byte, pulse data_in_strobe, and set data_in_start = first-byte flag; the flag SHALL then clear.
REQ-019 One clk after the strobe cycle, the block SHALL load the tx shift register with data_out so that the consumer's response to the strobed byte goes out in the next byte slot.
REQ-020 An SCLK falling edge with bit counter != 0 SHALL shift the tx register left by one; a falling edge with counter == 0 SHALL be ignored.
REQ-021 spi_io_dout SHALL equal tx register bit 7 in ACTIVE and 0 in IDLE.
REQ-022 An SS rising edge SHALL return the block to IDLE with no strobe; if the bit counter != 0, it SHALL pulse frame_err one cycle later and discard the partial byte.
REQ-023 When an SS edge and an SCLK edge are detected in the same cycle, the SS edge SHALL take precedence and the SCLK edge SHALL be ignored.
REQ-024 Correct operation SHALL require SCLK high and low phases of at least SYNC_STAGES+4 clk cycles each, and SS idle time of at least SYNC_STAGES+4 clk cycles.
REQ-025 Transactions SHALL have unbounded length; the first-byte flag SHALL re-arm only on an SS falling edge.

Reset
REQ-026 While reset_n is low, the block SHALL asynchronously force data_in_strobe=0, data_in_start=0, data_in=0x00, frame_err=0, spi_io_dout=0, state=IDLE, bit counter=0, rx and tx registers=0x00 and the first-byte flag=0.
REQ-027 A reset assertion mid-byte SHALL discard the partial byte with no strobe and no frame_err.
REQ-028 After reset_n is released, SS SHALL be treated as high, and no transaction SHALL start until an SS falling edge is detected.

Verification
REQ-029 Hold reset_n low with random SPI activity, then release with SS high -> all outputs 0; no strobe until the next SS fall.
REQ-030 Send one SS-low transaction with MOSI bytes 0x02, 0x01, 0xFF, 0x03 -> exactly 4 strobes; data_in 0x02/0x01/0xFF/0x03; data_in_start=1 only on 0x02.
REQ-031 Set data_out=0x5C before SS falls and change it to 0x42 in the cycle after the first strobe -> MISO byte 1 = 0x5C, byte 2 = 0x42, both MSB first.
REQ-032 Raise SS after 5 bits, then send a new transaction with byte 0xA5 -> no strobe for the partial byte; one frame_err pulse; 0xA5 strobed with data_in_start=1.
REQ-033 Assert reset_n low after 3 bits of byte 0x3C, release it, then send a new transaction with 0x81 -> outputs 0 during reset; no strobe and no frame_err for 0x3C; 0x81 strobed with start=1.
REQ-034 Send two back-to-back transactions with SS high for exactly the minimum idle time -> the first byte of each has data_in_start=1; no bytes are lost or merged.

Source files
------------

// File: rtl/mcu_spi_if.sv
// MCU SPI pins plus the byte-level handshake towards the consumer.
interface mcu_spi_if;
   logic       spi_io_ss;
   logic       spi_io_clk;
   logic       spi_io_din;
   logic       spi_io_dout;
   logic       data_in_strobe;
   logic       data_in_start;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       frame_err;

   // Block side: receives SPI pins and the response byte, produces received bytes.
   modport slave (
      input  spi_io_ss, spi_io_clk, spi_io_din, data_out,
      output spi_io_dout, data_in_strobe, data_in_start, data_in, frame_err
   );

   // MCU / consumer side.
   modport master (
      output spi_io_ss, spi_io_clk, spi_io_din, data_out,
      input  spi_io_dout, data_in_strobe, data_in_start, data_in, frame_err
   );
endinterface

// File: rtl/mcu_spi.sv
// SPI mode-0 slave oversampled by the system clock.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | synchronised SS high, MISO held low, SCLK ignored
// ST_ACTIVE | synchronised SS low, bytes shifted in/out on SCLK edges
module mcu_spi #(
   parameter int SYNC_STAGES = 2
) (
   input  logic     clk,
   input  logic     reset_n,
   mcu_spi_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
   logic                   ss_dly_q, sclk_dly_q;
   logic                   ss_s, sclk_s, din_s;
   logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       first_q, first_d;
   logic       load_q, load_d;
   logic       strobe_q, strobe_d;
   logic       start_q, start_d;
   logic [7:0] data_in_q, data_in_d;
   logic       frame_err_q, frame_err_d;

   // Synchroniser shift chains; the last stage is the usable synchronised value.
   always_comb begin
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_io_ss};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_io_clk};
      din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], bus.spi_io_din};
   end

   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign din_s     = din_sync_q[SYNC_STAGES-1];
   assign ss_fall   = ss_dly_q & ~ss_s;
   assign ss_rise   = ~ss_dly_q & ss_s;
   assign sclk_rise = ~sclk_dly_q & sclk_s;
   assign sclk_fall = sclk_dly_q & ~sclk_s;

   // Next state, shift registers and byte handshake; SS edges override SCLK edges.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      first_d     = first_q;
      load_d      = strobe_q;
      strobe_d    = 1'b0;
      start_d     = 1'b0;
      data_in_d   = data_in_q;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = 3'd0;
               rx_d      = 8'h00;
               first_d   = 1'b1;
               tx_d      = bus.data_out;
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               state_d     = ST_IDLE;
               bit_cnt_d   = 3'd0;
               rx_d        = 8'h00;
               frame_err_d = (bit_cnt_q != 3'd0);
            end else begin
               if (sclk_rise) begin
                  rx_d      = {rx_q[6:0], din_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     strobe_d  = 1'b1;
                     start_d   = first_q;
                     first_d   = 1'b0;
                     data_in_d = {rx_q[6:0], din_s};
                  end
               end
               // The falling edge right after a byte boundary is skipped so the
               // freshly loaded MSB stays on MISO for the first bit of the slot.
               if (load_q) begin
                  tx_d = bus.data_out;
               end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_sync_q   <= '1;
         sclk_sync_q <= '0;
         din_sync_q  <= '0;
         ss_dly_q    <= 1'b1;
         sclk_dly_q  <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         first_q     <= 1'b0;
         load_q      <= 1'b0;
         strobe_q    <= 1'b0;
         start_q     <= 1'b0;
         data_in_q   <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         din_sync_q  <= din_sync_d;
         ss_dly_q    <= ss_s;
         sclk_dly_q  <= sclk_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         first_q     <= first_d;
         load_q      <= load_d;
         strobe_q    <= strobe_d;
         start_q     <= start_d;
         data_in_q   <= data_in_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.spi_io_dout    = (state_q == ST_ACTIVE) & tx_q[7];
   assign bus.data_in_strobe = strobe_q;
   assign bus.data_in_start  = start_q;
   assign bus.data_in        = data_in_q;
   assign bus.frame_err      = frame_err_q;

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: bytes, MISO responses, framing errors, resets.
module tb_mcu_spi;

   localparam int HALF = 8;   // SCLK phase length in clk cycles
   localparam int IDLE_MIN = 6;

   logic clk;
   logic reset_n;
   mcu_spi_if bus();

   mcu_spi #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int err_cnt = 0;
   int chk_cnt = 0;
   int fe_cnt  = 0;
   logic [7:0] rec_data [$];
   logic       rec_start [$];
   logic [7:0] miso_rx [4];
   logic       swap_armed = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rec_d(input int i);
      return (i < rec_data.size()) ? {24'h0, rec_data[i]} : 32'hDEAD;
   endfunction

   function automatic logic [31:0] rec_s(input int i);
      return (i < rec_start.size()) ? {31'h0, rec_start[i]} : 32'hDEAD;
   endfunction

   // Record strobed bytes and frame errors.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.data_in_strobe) begin
            rec_data.push_back(bus.data_in);
            rec_start.push_back(bus.data_in_start);
         end
         if (bus.frame_err) fe_cnt++;
      end
   end

   // Consumer swaps its response in the cycle after the first strobe.
   always begin
      @(negedge clk);
      if (swap_armed && bus.data_in_strobe) begin
         @(posedge clk);
         #1;
         bus.data_out = 8'h42;
         swap_armed   = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.spi_io_din = b[i];
         wait_clk(HALF);
         miso = {miso[6:0], bus.spi_io_dout};
         bus.spi_io_clk = 1'b1;
         wait_clk(HALF);
         bus.spi_io_clk = 1'b0;
      end
   endtask

   task automatic send_xact(input logic [7:0] bytes [4], input int n, input int idle);
      logic [7:0] m;
      bus.spi_io_ss = 1'b0;
      wait_clk(HALF);
      for (int k = 0; k < n; k++) begin
         spi_bits(bytes[k], 8, m);
         miso_rx[k] = m;
      end
      wait_clk(HALF);
      bus.spi_io_ss  = 1'b1;
      bus.spi_io_din = 1'b0;
      wait_clk(idle);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_strobe"}, {31'h0, bus.data_in_strobe}, 32'h0);
      chk({tag, "_start"},  {31'h0, bus.data_in_start},  32'h0);
      chk({tag, "_data_in"}, {24'h0, bus.data_in},       32'h0);
      chk({tag, "_frame_err"}, {31'h0, bus.frame_err},   32'h0);
      chk({tag, "_dout"},   {31'h0, bus.spi_io_dout},    32'h0);
   endtask

   initial begin
      logic [7:0] m;
      reset_n         = 1'b0;
      bus.spi_io_ss   = 1'b1;
      bus.spi_io_clk  = 1'b0;
      bus.spi_io_din  = 1'b0;
      bus.data_out    = 8'h00;

      // Reset with random SPI activity.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus.spi_io_ss  = 1'($urandom);
         bus.spi_io_clk = 1'($urandom);
         bus.spi_io_din = 1'($urandom);
      end
      @(negedge clk);
      chk_outputs_zero("in_reset");
      bus.spi_io_ss  = 1'b1;
      bus.spi_io_clk = 1'b0;
      bus.spi_io_din = 1'b0;
      wait_clk(4);
      reset_n = 1'b1;
      wait_clk(20);
      @(negedge clk);
      chk_outputs_zero("post_reset");
      chk("post_reset_strobes", rec_data.size(), 0);

      // Four-byte transaction with response swap after the first strobe.
      bus.data_out = 8'h5C;
      swap_armed   = 1'b1;
      send_xact('{8'h02, 8'h01, 8'hFF, 8'h03}, 4, 12);
      chk("x1_strobes", rec_data.size(), 4);
      chk("x1_d0", rec_d(0), 32'h02);
      chk("x1_d1", rec_d(1), 32'h01);
      chk("x1_d2", rec_d(2), 32'hFF);
      chk("x1_d3", rec_d(3), 32'h03);
      chk("x1_s0", rec_s(0), 32'h1);
      chk("x1_s1", rec_s(1), 32'h0);
      chk("x1_s2", rec_s(2), 32'h0);
      chk("x1_s3", rec_s(3), 32'h0);
      chk("x1_miso0", {24'h0, miso_rx[0]}, 32'h5C);
      chk("x1_miso1", {24'h0, miso_rx[1]}, 32'h42);
      chk("x1_fe", fe_cnt, 0);
      chk("x1_dout_idle", {31'h0, bus.spi_io_dout}, 32'h0);

      // Partial byte then a clean transaction.
      rec_data.delete(); rec_start.delete(); fe_cnt = 0;
      bus.spi_io_ss = 1'b0;
      wait_clk(HALF);
      spi_bits(8'hF0, 5, m);
      wait_clk(HALF);
      bus.spi_io_ss = 1'b1;
      wait_clk(12);
      chk("fe_strobes", rec_data.size(), 0);
      chk("fe_pulses", fe_cnt, 1);
      send_xact('{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 12);
      chk("fe_next_strobes", rec_data.size(), 1);
      chk("fe_next_d0", rec_d(0), 32'hA5);
      chk("fe_next_s0", rec_s(0), 32'h1);
      chk("fe_next_pulses", fe_cnt, 1);

      // Reset in the middle of a byte.
      rec_data.delete(); rec_start.delete(); fe_cnt = 0;
      bus.spi_io_ss = 1'b0;
      wait_clk(HALF);
      spi_bits(8'h3C, 3, m);
      reset_n = 1'b0;
      wait_clk(3);
      @(negedge clk);
      chk_outputs_zero("mid_reset");
      bus.spi_io_ss = 1'b1;
      wait_clk(4);
      reset_n = 1'b1;
      wait_clk(15);
      chk("rst_strobes", rec_data.size(), 0);
      chk("rst_fe", fe_cnt, 0);
      send_xact('{8'h81, 8'h00, 8'h00, 8'h00}, 1, 12);
      chk("rst_next_strobes", rec_data.size(), 1);
      chk("rst_next_d0", rec_d(0), 32'h81);
      chk("rst_next_s0", rec_s(0), 32'h1);

      // Back-to-back transactions separated by the minimum idle time.
      rec_data.delete(); rec_start.delete(); fe_cnt = 0;
      send_xact('{8'h11, 8'h22, 8'h00, 8'h00}, 2, IDLE_MIN);
      send_xact('{8'h33, 8'hC4, 8'h00, 8'h00}, 2, 12);
      chk("b2b_strobes", rec_data.size(), 4);
      chk("b2b_d0", rec_d(0), 32'h11);
      chk("b2b_d1", rec_d(1), 32'h22);
      chk("b2b_d2", rec_d(2), 32'h33);
      chk("b2b_d3", rec_d(3), 32'hC4);
      chk("b2b_s0", rec_s(0), 32'h1);
      chk("b2b_s1", rec_s(1), 32'h0);
      chk("b2b_s2", rec_s(2), 32'h1);
      chk("b2b_s3", rec_s(3), 32'h0);
      chk("b2b_fe", fe_cnt, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
